// File: rtl/biss_pkg.sv
// Shared types and constants for the BiSS-C line sniffer.
package biss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_START,
        ST_CDS,
        ST_DATA,
        ST_STATUS,
        ST_CRC,
        ST_TIMEOUT
    } biss_state_e;

    localparam int unsigned CRC_W    = 6;
    localparam int unsigned BITS_W   = 8;
    localparam int unsigned STATUS_W = 2;

    // x^6 + x + 1 with the x^6 term implied
    localparam logic [CRC_W-1:0] CRC6_POLY = 6'h03;

endpackage

// File: rtl/biss_crc6.sv
// Serial MSB-first CRC6 engine, one message bit per enabled cycle.
module biss_crc6
    import biss_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             dat_i,
    output logic [CRC_W-1:0] crc_o
);

    logic fb_c;

    assign fb_c = crc_o[CRC_W-1] ^ dat_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            crc_o <= '0;
        end else if (clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb_c}} & CRC6_POLY);
        end
    end

endmodule

// File: rtl/biss_sniffer_c.sv
// Passive BiSS-C decoder: follows MA/SLO, checks CRC6, publishes good positions.
module biss_sniffer_c
    import biss_pkg::*;
#(
    parameter int unsigned POSN_W      = 48,
    parameter int unsigned TIMEOUT_CYC = 2500,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [7:0]        BITS,
    input  logic              SIGN_EXT,
    input  logic              ssi_sck_i,
    input  logic              ssi_dat_i,
    output logic [POSN_W-1:0] posn_o,
    output logic              posn_valid_o,
    output logic              err_o,
    output logic              warn_o,
    output logic              crc_err_o,
    output logic              frame_err_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] sck_s, dat_s;
    logic                   sck_e_q, rise_q, fall_q, dat_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   to_hit_c, abort_c, bits_ok_c, sign_c;

    biss_state_e         state_q, state_d;
    logic [BITS_W-1:0]   cnt_q, cnt_d, bits_q, bits_d;
    logic [POSN_W-1:0]   sr_q, sr_d, posn_d, hi_mask_c, posn_ext_c;
    logic [CRC_W-1:0]    rx_q, rx_d, crc_c;
    logic                sext_q, sext_d, ne_q, ne_d, nw_q, nw_d;
    logic                err_d, warn_d, valid_d, crc_err_d, frame_err_d;
    logic                crc_clr_c, crc_en_c;

    // Synchronisers and registered edge detect; idle-high reset avoids a false edge
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sck_s   <= '1;
            dat_s   <= '1;
            sck_e_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            dat_q   <= 1'b1;
        end else begin
            sck_s   <= SYNC_STAGES'({sck_s, ssi_sck_i});
            dat_s   <= SYNC_STAGES'({dat_s, ssi_dat_i});
            sck_e_q <= sck_s[SYNC_STAGES-1];
            rise_q  <= sck_s[SYNC_STAGES-1] & ~sck_e_q;
            fall_q  <= ~sck_s[SYNC_STAGES-1] & sck_e_q;
            dat_q   <= dat_s[SYNC_STAGES-1];
        end
    end

    // Saturating count of consecutive synchronised MA-high cycles
    always_ff @(posedge clk_i) begin
        if (!reset_ni || !sck_e_q) begin
            to_cnt_q <= '0;
        end else if (!to_hit_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_hit_c   = (to_cnt_q == TO_W'(TIMEOUT_CYC));
    assign abort_c    = to_hit_c && (state_q inside {ST_ACK, ST_START, ST_CDS,
                                                     ST_DATA, ST_STATUS, ST_CRC});
    assign bits_ok_c  = (BITS != '0) && (BITS <= BITS_W'(POSN_W));
    assign hi_mask_c  = {POSN_W{1'b1}} << bits_q;
    assign sign_c     = sext_q & (|(sr_q & (POSN_W'(1) << (bits_q - BITS_W'(1)))));
    assign posn_ext_c = sign_c ? (sr_q | hi_mask_c) : sr_q;

    biss_crc6 u_crc (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (crc_clr_c),
        .en_i     (crc_en_c),
        .dat_i    (dat_q),
        .crc_o    (crc_c)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bits_q       <= '0;
            sext_q       <= 1'b0;
            sr_q         <= '0;
            rx_q         <= '0;
            ne_q         <= 1'b0;
            nw_q         <= 1'b0;
            posn_o       <= '0;
            err_o        <= 1'b0;
            warn_o       <= 1'b0;
            posn_valid_o <= 1'b0;
            crc_err_o    <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bits_q       <= bits_d;
            sext_q       <= sext_d;
            sr_q         <= sr_d;
            rx_q         <= rx_d;
            ne_q         <= ne_d;
            nw_q         <= nw_d;
            posn_o       <= posn_d;
            err_o        <= err_d;
            warn_o       <= warn_d;
            posn_valid_o <= valid_d;
            crc_err_o    <= crc_err_d;
            frame_err_o  <= frame_err_d;
        end
    end

    // Frame sequencing; every slave bit is consumed on a detected MA rising edge
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bits_d      = bits_q;
        sext_d      = sext_q;
        sr_d        = sr_q;
        rx_d        = rx_q;
        ne_d        = ne_q;
        nw_d        = nw_q;
        posn_d      = posn_o;
        err_d       = err_o;
        warn_d      = warn_o;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        crc_clr_c   = 1'b0;
        crc_en_c    = 1'b0;

        if (abort_c) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fall_q && bits_ok_c) begin
                        state_d   = ST_ACK;
                        bits_d    = BITS;
                        sext_d    = SIGN_EXT;
                        cnt_d     = BITS - BITS_W'(1);
                        sr_d      = '0;
                        rx_d      = '0;
                        crc_clr_c = 1'b1;
                    end
                end
                ST_ACK: begin
                    if (rise_q && !dat_q) state_d = ST_START;
                end
                ST_START: begin
                    if (rise_q && dat_q) state_d = ST_CDS;
                end
                ST_CDS: begin
                    if (rise_q) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (rise_q) begin
                        sr_d     = {sr_q[POSN_W-2:0], dat_q};
                        crc_en_c = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = ST_STATUS;
                            cnt_d   = BITS_W'(STATUS_W - 1);
                        end else begin
                            cnt_d = cnt_q - BITS_W'(1);
                        end
                    end
                end
                ST_STATUS: begin
                    if (rise_q) begin
                        crc_en_c = 1'b1;
                        if (cnt_q == '0) begin
                            nw_d    = dat_q;
                            state_d = ST_CRC;
                            cnt_d   = BITS_W'(CRC_W - 1);
                        end else begin
                            ne_d  = dat_q;
                            cnt_d = cnt_q - BITS_W'(1);
                        end
                    end
                end
                ST_CRC: begin
                    if (rise_q) begin
                        rx_d = {rx_q[CRC_W-2:0], dat_q};
                        if (cnt_q == '0) begin
                            state_d = ST_TIMEOUT;
                            if (rx_d == ~crc_c) begin
                                posn_d  = posn_ext_c;
                                err_d   = ~ne_q;
                                warn_d  = ~nw_q;
                                valid_d = 1'b1;
                            end else begin
                                crc_err_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - BITS_W'(1);
                        end
                    end
                end
                ST_TIMEOUT: begin
                    if (to_hit_c) state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biss_sniffer_c.sv
// Randomised self-checking bench for biss_sniffer_c against a polynomial-division model.
module tb_biss_sniffer_c;

    localparam int unsigned POSN_W      = 48;
    localparam int unsigned TIMEOUT_CYC = 40;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 4;

    logic              clk = 1'b0;
    logic              reset_ni = 1'b0;
    logic [7:0]        BITS = 8'd19;
    logic              SIGN_EXT = 1'b0;
    logic              ssi_sck = 1'b1;
    logic              ssi_dat = 1'b1;
    logic [POSN_W-1:0] posn_o;
    logic              posn_valid_o, err_o, warn_o, crc_err_o, frame_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int n_valid = 0, n_crc = 0, n_ferr = 0, last_lat = 0;

    logic [POSN_W-1:0] m_posn = '0;
    logic              m_err = 1'b0, m_warn = 1'b0;

    biss_sniffer_c #(
        .POSN_W      (POSN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .BITS         (BITS),
        .SIGN_EXT     (SIGN_EXT),
        .ssi_sck_i    (ssi_sck),
        .ssi_dat_i    (ssi_dat),
        .posn_o       (posn_o),
        .posn_valid_o (posn_valid_o),
        .err_o        (err_o),
        .warn_o       (warn_o),
        .crc_err_o    (crc_err_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        if (posn_valid_o) begin
            n_valid  = n_valid + 1;
            last_lat = cyc - rise_cyc;
        end
        if (crc_err_o) begin
            n_crc    = n_crc + 1;
            last_lat = cyc - rise_cyc;
        end
        if (frame_err_o) n_ferr = n_ferr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x) * x^6 divided by x^6 + x + 1
    function automatic logic [5:0] crc6_ref(input logic [65:0] msg, input int n);
        logic [71:0] r;
        r = 72'(msg) << 6;
        for (int i = n + 5; i >= 6; i--)
            if (r[i]) r = r ^ (72'h43 << (i - 6));
        return r[5:0];
    endfunction

    task automatic ma_bit(input logic b);
        @(posedge clk);
        #2;
        ssi_sck = 1'b0;
        ssi_dat = b;
        repeat (HALF) @(posedge clk);
        #2;
        ssi_sck  = 1'b1;
        rise_cyc = cyc;
        repeat (HALF - 1) @(posedge clk);
    endtask

    task automatic run_frame(input string tag, input int nb, input logic [7:0] bits_port,
                             input logic [63:0] pos, input logic sx, input logic ne,
                             input logic nw, input int flip, input int stop_at, input bit do_rst);
        logic [63:0] v;
        logic [65:0] msg;
        logic [5:0]  tx_crc;
        int          v0, c0, f0, sent;
        bit          legal, aborted, exp_good, exp_bad, exp_ferr;
        v0 = n_valid; c0 = n_crc; f0 = n_ferr;
        legal   = (bits_port != 8'd0) && (bits_port <= 8'(POSN_W));
        aborted = 1'b0;
        sent    = 0;
        v       = pos & ((64'd1 << nb) - 64'd1);
        msg     = (66'(v) << 2) | 66'({ne, nw});
        tx_crc  = ~crc6_ref(msg, nb + 2);
        if (flip >= 0) tx_crc[flip] = ~tx_crc[flip];
        BITS     = bits_port;
        SIGN_EXT = sx;

        ma_bit(1'b1);
        if (legal) begin
            BITS     = 8'($urandom);
            SIGN_EXT = 1'($urandom);
        end
        ma_bit(1'b0);
        ma_bit(1'b0);
        ma_bit(1'b1);
        ma_bit(1'($urandom));
        for (int i = nb - 1; i >= 0 && !aborted; i--) begin
            if (sent == stop_at) begin
                aborted = 1'b1;
            end else begin
                ma_bit(v[i]);
                sent++;
            end
        end
        if (!aborted) begin
            ma_bit(ne);
            ma_bit(nw);
            for (int i = 5; i >= 0; i--) ma_bit(tx_crc[i]);
        end else if (do_rst) begin
            @(posedge clk);
            #2 reset_ni = 1'b0;
            repeat (3) @(posedge clk);
            #2 reset_ni = 1'b1;
            m_posn = '0;
            m_err  = 1'b0;
            m_warn = 1'b0;
            @(posedge clk);
            #1;
            chk({tag, ".rst_posn"}, 64'(posn_o), 64'd0);
            chk({tag, ".rst_flags"}, 64'({err_o, warn_o, posn_valid_o, crc_err_o, frame_err_o}), 64'd0);
        end
        repeat (TIMEOUT_CYC + 20) @(posedge clk);
        #1;

        exp_good = legal && !aborted && (flip < 0);
        exp_bad  = legal && !aborted && (flip >= 0);
        exp_ferr = legal && aborted && !do_rst;
        if (exp_good) begin
            if (sx && v[nb-1]) v = v - (64'd1 << nb);
            m_posn = v[POSN_W-1:0];
            m_err  = ~ne;
            m_warn = ~nw;
        end
        chk({tag, ".valid_cnt"}, 64'(n_valid - v0), 64'(exp_good));
        chk({tag, ".crc_err_cnt"}, 64'(n_crc - c0), 64'(exp_bad));
        chk({tag, ".frame_err_cnt"}, 64'(n_ferr - f0), 64'(exp_ferr));
        chk({tag, ".posn"}, 64'(posn_o), 64'(m_posn));
        chk({tag, ".err"}, 64'(err_o), 64'(m_err));
        chk({tag, ".warn"}, 64'(warn_o), 64'(m_warn));
        if (exp_good || exp_bad) chk({tag, ".latency"}, 64'(last_lat), 64'(SYNC_STAGES + 2));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.posn", 64'(posn_o), 64'd0);
        chk("reset.flags", 64'({err_o, warn_o, posn_valid_o, crc_err_o, frame_err_o}), 64'd0);

        run_frame("good19", 19, 8'd19, 64'h5A5A5, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("crcflip", 19, 8'd19, 64'h5A5A5, 1'b0, 1'b1, 1'b1, 2, -1, 1'b0);
        run_frame("sext", 19, 8'd19, 64'h40000, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("ne0", 19, 8'd19, 64'h12345, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        run_frame("ne0_crcbad", 19, 8'd19, 64'h00001, 1'b0, 1'b1, 1'b0, 5, -1, 1'b0);
        run_frame("ne1", 19, 8'd19, 64'h54321, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
        run_frame("abort10", 19, 8'd19, 64'h7FFFF, 1'b0, 1'b1, 1'b1, -1, 10, 1'b0);
        run_frame("after_abort", 19, 8'd19, 64'h5A5A5, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("rst_data", 19, 8'd19, 64'h3C3C3, 1'b0, 1'b1, 1'b1, -1, 7, 1'b1);
        run_frame("after_rst", 19, 8'd19, 64'h5A5A5, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        run_frame("bits0", 19, 8'd0, 64'h11111, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("bits49", 19, 8'd49, 64'h22222, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("bits8", 8, 8'd8, 64'h80, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame("bits48", 48, 8'd48, 64'h8000_0000_0001, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);

        for (int k = 0; k < 14; k++) begin
            int nb, fl;
            nb = int'($urandom_range(8, POSN_W));
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_frame($sformatf("rnd%0d", k), nb, 8'(nb), {$urandom, $urandom},
                      1'($urandom), 1'($urandom), 1'($urandom), fl, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
